// File: rtl/median_window_feeder.sv
// median_window_feeder: buffers a raster grey image in three line buffers and streams
// each 3x3 neighbourhood to MEDIAN. Define WINDOW_ZERO_PAD_EN to zero-pad image borders.
module median_window_feeder #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [7:0] PIX_IN,
    input  logic       PIX_IN_VALID,
    output logic       PIX_IN_READY,
    output logic [7:0] M_DI,
    output logic       M_DSI,
    input  logic [7:0] M_DO,
    input  logic       M_DSO,
    output logic [7:0] PIX_OUT,
    output logic       PIX_OUT_VALID,
    output logic       FRAME_DONE
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] XLAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YLAST = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] YPRE  = YW'(HEIGHT - 2);

    typedef enum logic [2:0] {
        LOAD0,
        LOAD1,
        LOADN,
        EMIT,
        WAIT,
        NEXTROW
    } state_t;

    state_t state;

    logic [7:0]    buf0 [WIDTH];
    logic [7:0]    buf1 [WIDTH];
    logic [7:0]    buf2 [WIDTH];

    logic [1:0]    top_sel;
    logic [1:0]    mid_sel;
    logic [1:0]    bot_sel;
    logic [1:0]    ld_sel;
    logic [XW-1:0] x;
    logic [XW-1:0] lc;
    logic [YW-1:0] y;
    logic [1:0]    wrow;
    logic [1:0]    wcol;
    logic [3:0]    ecnt;

    logic          load_fire;
    logic [1:0]    rd_sel;
    logic [XW-1:0] rd_col;
    logic [7:0]    rd_pix;
    logic [7:0]    word;

    assign load_fire = PIX_IN_VALID && PIX_IN_READY;

    // Window word for the current (wrow, wcol) position; columns clamp at the image edges.
    always_comb begin
        rd_sel = bot_sel;
        if (wrow == 2'd0) begin
            rd_sel = top_sel;
        end else if (wrow == 2'd1) begin
            rd_sel = mid_sel;
        end

        rd_col = x;
        if (wcol == 2'd0 && x != '0) begin
            rd_col = x - XW'(1);
        end else if (wcol == 2'd2 && x != XLAST) begin
            rd_col = x + XW'(1);
        end

        case (rd_sel)
            2'd0:    rd_pix = buf0[rd_col];
            2'd1:    rd_pix = buf1[rd_col];
            default: rd_pix = buf2[rd_col];
        endcase

`ifdef WINDOW_ZERO_PAD_EN
        word = rd_pix;
        if ((wcol == 2'd0 && x == '0) || (wcol == 2'd2 && x == XLAST) ||
            (wrow == 2'd0 && y == '0) || (wrow == 2'd2 && y == YLAST)) begin
            word = 8'h00;
        end
`else
        word = rd_pix;
`endif
    end

    always_ff @(posedge CLK) begin
        if (load_fire) begin
            case (ld_sel)
                2'd0:    buf0[lc] <= PIX_IN;
                2'd1:    buf1[lc] <= PIX_IN;
                default: buf2[lc] <= PIX_IN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state         <= LOAD0;
            PIX_IN_READY  <= 1'b0;
            M_DI          <= '0;
            M_DSI         <= 1'b0;
            PIX_OUT       <= '0;
            PIX_OUT_VALID <= 1'b0;
            FRAME_DONE    <= 1'b0;
            x             <= '0;
            y             <= '0;
            lc            <= '0;
            ecnt          <= '0;
            wrow          <= '0;
            wcol          <= '0;
            top_sel       <= 2'd0;
            mid_sel       <= 2'd0;
            bot_sel       <= 2'd1;
            ld_sel        <= 2'd0;
        end else begin
            PIX_OUT_VALID <= 1'b0;
            FRAME_DONE    <= 1'b0;

            case (state)
                LOAD0, LOAD1, LOADN: begin
                    PIX_IN_READY <= 1'b1;
                    if (load_fire) begin
                        if (lc == XLAST) begin
                            lc <= '0;
                            x  <= '0;
                            case (state)
                                LOAD0: begin
                                    state  <= LOAD1;
                                    ld_sel <= 2'd1;
                                end
                                LOAD1: begin
                                    state        <= EMIT;
                                    PIX_IN_READY <= 1'b0;
                                    top_sel      <= 2'd0;
                                    mid_sel      <= 2'd0;
                                    bot_sel      <= 2'd1;
                                    y            <= '0;
                                end
                                default: begin
                                    // At y=0 TOP==MID, so this rotation also yields buf0/buf1/buf2.
                                    state        <= EMIT;
                                    PIX_IN_READY <= 1'b0;
                                    top_sel      <= mid_sel;
                                    mid_sel      <= bot_sel;
                                    bot_sel      <= ld_sel;
                                    y            <= y + YW'(1);
                                end
                            endcase
                        end else begin
                            lc <= lc + XW'(1);
                        end
                    end
                end

                EMIT: begin
                    M_DSI <= 1'b1;
                    M_DI  <= word;
                    if (wcol == 2'd2) begin
                        wcol <= '0;
                        wrow <= wrow + 2'd1;
                    end else begin
                        wcol <= wcol + 2'd1;
                    end
                    if (ecnt == 4'd8) begin
                        ecnt  <= '0;
                        wrow  <= '0;
                        wcol  <= '0;
                        state <= WAIT;
                    end else begin
                        ecnt <= ecnt + 4'd1;
                    end
                end

                WAIT: begin
                    M_DSI <= 1'b0;
                    if (M_DSO && !M_DSI) begin
                        PIX_OUT       <= M_DO;
                        PIX_OUT_VALID <= 1'b1;
                        if (x == XLAST) begin
                            x          <= '0;
                            FRAME_DONE <= (y == YLAST);
                            state      <= NEXTROW;
                        end else begin
                            x     <= x + XW'(1);
                            state <= EMIT;
                        end
                    end
                end

                NEXTROW: begin
                    if (y == YLAST) begin
                        y      <= '0;
                        ld_sel <= 2'd0;
                        state  <= LOAD0;
                    end else if (y == '0 && HEIGHT > 2) begin
                        ld_sel <= 2'd2;
                        state  <= LOADN;
                    end else if (y < YPRE) begin
                        ld_sel <= top_sel;
                        state  <= LOADN;
                    end else begin
                        top_sel <= mid_sel;
                        mid_sel <= bot_sel;
                        y       <= y + YW'(1);
                        state   <= EMIT;
                    end
                end

                default: state <= LOAD0;
            endcase
        end
    end

endmodule

// File: tb/tb_median_window_feeder.sv
// tb_median_window_feeder: drives 4x3 frames, models MEDIAN, and scores windows and outputs
// against a direct-indexing neighbourhood reference with a bubble-sort median.
`timescale 1ns/1ps
module tb_median_window_feeder;

    localparam int TB_W = 4;
    localparam int TB_H = 3;
    localparam int NPIX = TB_W * TB_H;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [7:0] PIX_IN = '0;
    logic       PIX_IN_VALID = 1'b0;
    logic       PIX_IN_READY;
    logic [7:0] M_DI;
    logic       M_DSI;
    logic [7:0] M_DO = '0;
    logic       M_DSO = 1'b0;
    logic [7:0] PIX_OUT;
    logic       PIX_OUT_VALID;
    logic       FRAME_DONE;

    median_window_feeder #(.WIDTH(TB_W), .HEIGHT(TB_H)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .PIX_IN        (PIX_IN),
        .PIX_IN_VALID  (PIX_IN_VALID),
        .PIX_IN_READY  (PIX_IN_READY),
        .M_DI          (M_DI),
        .M_DSI         (M_DSI),
        .M_DO          (M_DO),
        .M_DSO         (M_DSO),
        .PIX_OUT       (PIX_OUT),
        .PIX_OUT_VALID (PIX_OUT_VALID),
        .FRAME_DONE    (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned stray_fd = 0;

    logic [7:0]  frame [TB_H][TB_W];
    logic [7:0]  out_q [$];
    logic        fd_q  [$];
    logic [71:0] win_q [$];
    logic [71:0] exp_w [NPIX];
    logic [7:0]  exp_m [NPIX];

    int unsigned lat_a = 5;
    int unsigned lat_b = 5;
    bit          alt_sel = 1'b0;
    bit          busy = 1'b0;
    int unsigned lat_cnt = 0;
    int unsigned run_len = 0;
    logic [71:0] cur_w = '0;
    logic [7:0]  med_pend = '0;

    function automatic logic [7:0] median9(input logic [71:0] w);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = w[8*(8-i) +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    function automatic logic [7:0] ref_pix(input int yy, input int xx);
`ifdef WINDOW_ZERO_PAD_EN
        if (yy < 0 || yy >= TB_H || xx < 0 || xx >= TB_W) return 8'h00;
`else
        if (yy < 0) yy = 0;
        if (yy >= TB_H) yy = TB_H - 1;
        if (xx < 0) xx = 0;
        if (xx >= TB_W) xx = TB_W - 1;
`endif
        return frame[yy][xx];
    endfunction

    // MEDIAN model: collects 9 words under DSI, answers with the median after a latency.
    always @(negedge CLK) begin
        M_DSO = 1'b0;
        if (!nRST) begin
            busy    = 1'b0;
            run_len = 0;
        end else begin
            if (M_DSI === 1'b1) begin
                n_cmp++;
                if (busy) begin
                    n_bad++;
                    $display("FAIL dsi_before_dso: M_DSI=1 while previous window still pending");
                end
                cur_w = {cur_w[63:0], M_DI};
                run_len++;
                if (run_len == 9) begin
                    win_q.push_back(cur_w);
                    med_pend = median9(cur_w);
                    busy     = 1'b1;
                    lat_cnt  = alt_sel ? lat_b : lat_a;
                    alt_sel  = !alt_sel;
                end
            end else begin
                if (run_len != 0) begin
                    n_cmp++;
                    if (run_len != 9) begin
                        n_bad++;
                        $display("FAIL dsi_length: got %0d cycles, expected 9", run_len);
                    end
                    run_len = 0;
                end
                if (busy) begin
                    if (lat_cnt <= 1) begin
                        M_DSO = 1'b1;
                        M_DO  = med_pend;
                        busy  = 1'b0;
                    end else begin
                        lat_cnt--;
                    end
                end
            end
            if (M_DSI === 1'b1 || busy) begin
                n_cmp++;
                if (PIX_IN_READY !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ready_during_window: PIX_IN_READY=%b, expected 0", PIX_IN_READY);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (PIX_OUT_VALID === 1'b1) begin
            out_q.push_back(PIX_OUT);
            fd_q.push_back(FRAME_DONE);
        end else if (FRAME_DONE === 1'b1) begin
            stray_fd++;
        end
    end

    task automatic clear_queues();
        out_q.delete();
        fd_q.delete();
        win_q.delete();
    endtask

    task automatic build_expected();
        logic [71:0] w;
        for (int yy = 0; yy < TB_H; yy++)
            for (int xx = 0; xx < TB_W; xx++) begin
                w = '0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        w = {w[63:0], ref_pix(yy + dr, xx + dc)};
                exp_w[yy*TB_W + xx] = w;
                exp_m[yy*TB_W + xx] = median9(w);
            end
    endtask

    task automatic drive_frame(input bit gaps, output bit ok);
        bit acc;
        int budget;
        ok = 1'b1;
        for (int yy = 0; yy < TB_H; yy++)
            for (int xx = 0; xx < TB_W; xx++) begin
                if (gaps) begin
                    PIX_IN_VALID = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge CLK);
                end
                PIX_IN       = frame[yy][xx];
                PIX_IN_VALID = 1'b1;
                acc    = 1'b0;
                budget = 0;
                while (!acc && budget < 5000) begin
                    acc = (PIX_IN_READY === 1'b1);
                    @(negedge CLK);
                    budget++;
                end
                if (!acc) ok = 1'b0;
            end
        PIX_IN_VALID = 1'b0;
    endtask

    task automatic wait_outputs(input int n, output bit ok);
        int budget = 0;
        while (out_q.size() < n && budget < 20000) begin
            @(negedge CLK);
            budget++;
        end
        repeat (40) @(negedge CLK);
        ok = (out_q.size() >= n);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        PIX_IN_VALID = 1'b1;
        PIX_IN = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ({PIX_IN_READY, M_DI, M_DSI, PIX_OUT, PIX_OUT_VALID, FRAME_DONE} !== 20'h0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %h, expected 0",
                         {PIX_IN_READY, M_DI, M_DSI, PIX_OUT, PIX_OUT_VALID, FRAME_DONE});
            end
        end
        nRST = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (PIX_IN_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b, expected 1", PIX_IN_READY);
        end
        PIX_IN_VALID = 1'b0;
    endtask

    task automatic test_constant();
        bit ok_in, ok_out;
        for (int yy = 0; yy < TB_H; yy++)
            for (int xx = 0; xx < TB_W; xx++) frame[yy][xx] = 8'h55;
        lat_a = 5; lat_b = 5;
        clear_queues();
        drive_frame(1'b0, ok_in);
        wait_outputs(NPIX, ok_out);
        n_cmp++;
        if (!(ok_in && ok_out)) begin
            n_bad++;
            $display("FAIL const_timeout: in_ok=%b out_ok=%b, expected 1/1", ok_in, ok_out);
        end
        n_cmp++;
        if (out_q.size() != NPIX) begin
            n_bad++;
            $display("FAIL const_count: got %0d outputs, expected %0d", out_q.size(), NPIX);
        end
        for (int i = 0; i < out_q.size() && i < NPIX; i++) begin
            n_cmp++;
            if (out_q[i] !== 8'h55) begin
                n_bad++;
                $display("FAIL const_pix[%0d]: got %h, expected 55", i, out_q[i]);
            end
            n_cmp++;
            if (fd_q[i] !== (i == NPIX - 1)) begin
                n_bad++;
                $display("FAIL const_frame_done[%0d]: got %b, expected %b", i, fd_q[i], i == NPIX - 1);
            end
        end
        n_cmp++;
        if (stray_fd != 0) begin
            n_bad++;
            $display("FAIL const_stray_frame_done: got %0d, expected 0", stray_fd);
        end
    endtask

    task automatic test_window_order();
        bit ok_in, ok_out;
        logic [71:0] w00, w32;
`ifdef WINDOW_ZERO_PAD_EN
        w00 = 72'h00_00_00_00_00_01_00_10_11;
        w32 = 72'h12_13_00_22_23_00_00_00_00;
`else
        w00 = 72'h00_00_01_00_00_01_10_10_11;
        w32 = 72'h12_13_13_22_23_23_22_23_23;
`endif
        for (int yy = 0; yy < TB_H; yy++)
            for (int xx = 0; xx < TB_W; xx++) frame[yy][xx] = 8'(16*yy + xx);
        build_expected();
        lat_a = 3; lat_b = 3;
        clear_queues();
        drive_frame(1'b0, ok_in);
        wait_outputs(NPIX, ok_out);
        n_cmp++;
        if (win_q.size() != NPIX || !(ok_in && ok_out)) begin
            n_bad++;
            $display("FAIL order_count: got %0d windows, expected %0d", win_q.size(), NPIX);
        end
        if (win_q.size() == NPIX) begin
            n_cmp++;
            if (win_q[0] !== w00) begin
                n_bad++;
                $display("FAIL order_win00: got %h, expected %h", win_q[0], w00);
            end
            n_cmp++;
            if (win_q[NPIX-1] !== w32) begin
                n_bad++;
                $display("FAIL order_win32: got %h, expected %h", win_q[NPIX-1], w32);
            end
        end
        for (int i = 0; i < win_q.size() && i < NPIX; i++) begin
            n_cmp++;
            if (win_q[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL order_win[%0d]: got %h, expected %h", i, win_q[i], exp_w[i]);
            end
        end
        for (int i = 0; i < out_q.size() && i < NPIX; i++) begin
            n_cmp++;
            if (out_q[i] !== exp_m[i]) begin
                n_bad++;
                $display("FAIL order_pix[%0d]: got %h, expected %h", i, out_q[i], exp_m[i]);
            end
        end
    endtask

    task automatic test_handshake();
        bit ok_in, ok_out;
        lat_a = 1; lat_b = 20;
        for (int f = 0; f < 2; f++) begin
            for (int yy = 0; yy < TB_H; yy++)
                for (int xx = 0; xx < TB_W; xx++) frame[yy][xx] = 8'($urandom_range(0, 255));
            build_expected();
            clear_queues();
            drive_frame(1'b1, ok_in);
            wait_outputs(NPIX, ok_out);
            n_cmp++;
            if (out_q.size() != NPIX || !(ok_in && ok_out)) begin
                n_bad++;
                $display("FAIL hs_count[%0d]: got %0d outputs, expected %0d", f, out_q.size(), NPIX);
            end
            for (int i = 0; i < out_q.size() && i < NPIX; i++) begin
                n_cmp++;
                if (out_q[i] !== exp_m[i] || fd_q[i] !== (i == NPIX - 1)) begin
                    n_bad++;
                    $display("FAIL hs_pix[%0d][%0d]: got %h/%b, expected %h/%b",
                             f, i, out_q[i], fd_q[i], exp_m[i], i == NPIX - 1);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok_in, ok_out;
        int budget = 0;
        for (int yy = 0; yy < TB_H; yy++)
            for (int xx = 0; xx < TB_W; xx++) frame[yy][xx] = 8'($urandom_range(0, 255));
        lat_a = 20; lat_b = 20;
        clear_queues();
        drive_frame(1'b1, ok_in);
        while (!(win_q.size() == 7 && M_DSI === 1'b0 && busy && lat_cnt > 5) && budget < 5000) begin
            @(negedge CLK);
            budget++;
        end
        n_cmp++;
        if (budget >= 5000 || !ok_in) begin
            n_bad++;
            $display("FAIL mid_reach_wait: windows=%0d, expected 7 with window (2,1) pending", win_q.size());
        end
        nRST = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({M_DSI, PIX_OUT_VALID, PIX_IN_READY, FRAME_DONE} !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: dsi/valid/ready/done=%b, expected 0000",
                     {M_DSI, PIX_OUT_VALID, PIX_IN_READY, FRAME_DONE});
        end
        @(negedge CLK);
        #1;
        clear_queues();
        @(negedge CLK);
        nRST = 1'b1;
        for (int yy = 0; yy < TB_H; yy++)
            for (int xx = 0; xx < TB_W; xx++) frame[yy][xx] = 8'hA0;
        build_expected();
        lat_a = 2; lat_b = 2;
        drive_frame(1'b0, ok_in);
        wait_outputs(NPIX, ok_out);
        n_cmp++;
        if (out_q.size() != NPIX || !(ok_in && ok_out)) begin
            n_bad++;
            $display("FAIL mid_count: got %0d outputs, expected %0d", out_q.size(), NPIX);
        end
        for (int i = 0; i < out_q.size() && i < NPIX; i++) begin
            n_cmp++;
            if (out_q[i] !== exp_m[i] || fd_q[i] !== (i == NPIX - 1)) begin
                n_bad++;
                $display("FAIL mid_pix[%0d]: got %h/%b, expected %h/%b",
                         i, out_q[i], fd_q[i], exp_m[i], i == NPIX - 1);
            end
        end
        for (int i = 0; i < win_q.size() && i < NPIX; i++) begin
            n_cmp++;
            if (win_q[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL mid_win[%0d]: got %h, expected %h", i, win_q[i], exp_w[i]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_constant();
        test_window_order();
        test_handshake();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/median_window_feeder.md
Name: median_window_feeder

Overview:
- Hardware front end for the MEDIAN filter core.
- Accepts an 8-bit grey image as a raster pixel stream and buffers it in three line buffers.
- For every output pixel, streams the 3x3 neighbourhood to MEDIAN as 9 consecutive DI words under DSI, waits for DSO, then emits the median on a raster output stream.
- Replaces the software window generation used in simulation, so a full frame can be filtered in hardware.

Parameters:
- WIDTH, 256: image width in pixels, >= 2.
- HEIGHT, 256: image height in lines, >= 2.

Ports:
- CLK, input, 1: single clock, all logic on rising edge.
- nRST, input, 1: reset, synchronous, active-low.
- PIX_IN, input, 8: raster input pixel.
- PIX_IN_VALID, input, 1: PIX_IN valid.
- PIX_IN_READY, output, 1: feeder accepts PIX_IN this cycle.
- M_DI, output, 8: window word to MEDIAN DI.
- M_DSI, output, 1: to MEDIAN DSI; high for exactly 9 consecutive cycles per window.
- M_DO, input, 8: MEDIAN DO.
- M_DSO, input, 1: MEDIAN DSO; M_DO valid.
- PIX_OUT, output, 8: filtered pixel, raster order.
- PIX_OUT_VALID, output, 1: one-cycle pulse per filtered pixel.
- FRAME_DONE, output, 1: one-cycle pulse with the last PIX_OUT_VALID of a frame.

Behaviour:
- Interface: one clock CLK; reset nRST is synchronous and active-low.
- Reset values: PIX_IN_READY=0, M_DI=0, M_DSI=0, PIX_OUT=0, PIX_OUT_VALID=0, FRAME_DONE=0. State=LOAD0; x, y, load counter = 0.
- Reset mid-operation: aborts the frame immediately, drops M_DSI the next cycle, discards buffered lines. MEDIAN is reset by the same nRST.
- Input transfer: occurs when PIX_IN_VALID && PIX_IN_READY. PIX_IN_READY=1 only in LOAD0, LOAD1 and LOADN; the input is stalled during window emission.
- Line buffers: three physical WIDTH x 8 register arrays, async read. Logical pointers TOP, MID, BOT.
- LOAD0: store line 0 into buf0 (WIDTH transfers) -> LOAD1.
- LOAD1: store line 1 into buf1. Set TOP=MID=buf0 (top clamp), BOT=buf1, y=0 -> EMIT.
- EMIT: 9 cycles, M_DSI=1, M_DI in this order:
  - TOP[x-1], TOP[x], TOP[x+1]
  - MID[x-1], MID[x], MID[x+1]
  - BOT[x-1], BOT[x], BOT[x+1]
  - Column clamp: x-1<0 -> 0; x+1=WIDTH -> WIDTH-1.
  - First word is driven in the first cycle after state entry; M_DSI falls after the 9th word -> WAIT.
- WAIT: M_DSI=0, M_DI holds its last value; wait indefinitely for M_DSO=1. A DSO arriving during EMIT is ignored (protocol violation, not expected).
- Output: on the M_DSO cycle, latch M_DO. Next cycle PIX_OUT=latched value, PIX_OUT_VALID=1 (PIX_OUT holds afterwards). Then:
  - x<WIDTH-1: x++ -> EMIT.
  - Otherwise x=0 -> NEXTROW.
- NEXTROW:
  - y=HEIGHT-1: FRAME_DONE=1 together with the final PIX_OUT_VALID -> LOAD0 (new frame).
  - y=0 and HEIGHT>2: load line 2 into buf2 (LOADN), then TOP=buf0, MID=buf1, BOT=buf2.
  - y>=1 and y+2<HEIGHT: load line y+2 into TOP's buffer (LOADN), then rotate TOP<-MID, MID<-BOT, BOT<-reloaded buffer.
  - y+2=HEIGHT: no load; TOP<-MID, MID<-BOT, BOT unchanged (bottom clamp).
  - y++ -> EMIT.
- Minimum spacing: 11 cycles between windows (9 EMIT + DSO + output), plus MEDIAN latency.
- A PIX_IN_VALID pulse while READY=0 is not consumed; the source must hold it.

Optional Feature:
- Macro: WINDOW_ZERO_PAD_EN.
- Defined: out-of-image neighbours (row or column outside 0..HEIGHT-1 / 0..WIDTH-1) are sent as 8'h00 instead of clamped; the load and rotation sequence is unchanged.
- Undefined: edge replication (clamping) as described in Behaviour.

Test Plan:
- Reset: hold nRST=0 for 3 cycles with PIX_IN_VALID=1 -> all outputs 0, no transfer. One cycle after release PIX_IN_READY=1.
- Constant frame: WIDTH=4, HEIGHT=3, all pixels 8'h55, MEDIAN model with 5-cycle DSO latency -> 12 PIX_OUT_VALID pulses all 8'h55; FRAME_DONE exactly on the 12th; PIX_IN_READY=0 during every EMIT/WAIT.
- Window order: 4x3 frame, pixel value = 16*y+x.
  - Window (0,0) -> M_DI = 00,00,01,00,00,01,10,10,11.
  - Window (3,2) -> M_DI = 12,13,13,22,23,23,22,23,23.
  - M_DSI high exactly 9 cycles each.
- Handshake timing: MEDIAN model DSO latency alternated between 1 and 20 cycles, random PIX_IN_VALID gaps -> no M_DSI before the preceding DSO; PIX_OUT sequence matches a bubble-sort reference over the clamped windows.
- Reset mid-frame: nRST=0 during WAIT of window (2,1), then a fresh constant 8'hA0 frame -> M_DSI falls the next cycle; no stale output; 12 outputs of 8'hA0.
- WINDOW_ZERO_PAD_EN defined, 16*y+x frame -> window (0,0) M_DI = 00,00,00,00,00,01,00,10,11; PIX_OUT(0,0)=00.
